// File: rtl/wb_pkg.sv
// Shared entry type, source-select encoding and default sizing for the
// register writeback controller and its LSU write queue.
package wb_pkg;

  localparam int unsigned WB_DATA_WIDTH    = 32;
  localparam int unsigned WB_ADDRESS_WIDTH = 5;
  localparam int unsigned WB_QUEUE_DEPTH   = 4;
  localparam int unsigned WB_STARVE_LIMIT  = 4;

  // The entry layout is fixed by the constants above, so instances must keep
  // DATA_WIDTH/ADDRESS_WIDTH at these values.
  typedef struct packed {
    logic                        valid;
    logic [WB_ADDRESS_WIDTH-1:0] rd;
    logic [WB_DATA_WIDTH-1:0]    data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    SRC_NONE  = 2'd0,
    SRC_PIPE  = 2'd1,
    SRC_QUEUE = 2'd2
  } wb_src_e;

endpackage

// File: rtl/reg_writeback_ctrl_if.sv
// Pipeline/LSU writeback request bus plus register-file write port and status.
interface reg_writeback_ctrl_if #(
  parameter int unsigned DATA_WIDTH    = wb_pkg::WB_DATA_WIDTH,
  parameter int unsigned ADDRESS_WIDTH = wb_pkg::WB_ADDRESS_WIDTH,
  parameter int unsigned QUEUE_DEPTH   = wb_pkg::WB_QUEUE_DEPTH
);

  logic                          pipe_valid;
  logic [ADDRESS_WIDTH-1:0]      pipe_rd;
  logic [DATA_WIDTH-1:0]         pipe_data;
  logic                          pipe_stall;

  logic                          lsu_valid;
  logic                          lsu_ready;
  logic [ADDRESS_WIDTH-1:0]      lsu_rd;
  logic [DATA_WIDTH-1:0]         lsu_data;

  logic                          WE3;
  logic [ADDRESS_WIDTH-1:0]      A3;
  logic [DATA_WIDTH-1:0]         WD3;

  logic [2**ADDRESS_WIDTH-1:0]   pending_mask;
  logic [$clog2(QUEUE_DEPTH):0]  queue_count;

  modport master (
    output pipe_valid, pipe_rd, pipe_data,
    output lsu_valid, lsu_rd, lsu_data,
    input  pipe_stall, lsu_ready,
    input  WE3, A3, WD3,
    input  pending_mask, queue_count
  );

  modport slave (
    input  pipe_valid, pipe_rd, pipe_data,
    input  lsu_valid, lsu_rd, lsu_data,
    output pipe_stall, lsu_ready,
    output WE3, A3, WD3,
    output pending_mask, queue_count
  );

endinterface

// File: rtl/wb_queue.sv
// Compacting FIFO of pending LSU writes: entries stay packed from slot 0 (head),
// so killed entries vanish the same edge and count always equals occupancy.
module wb_queue
  import wb_pkg::*;
#(
  parameter  int unsigned DEPTH = WB_QUEUE_DEPTH,
  localparam int unsigned CW    = $clog2(DEPTH) + 1,
  localparam int unsigned IW    = $clog2(DEPTH),
  localparam int unsigned NREG  = 2**WB_ADDRESS_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push_i,
  input  logic [WB_ADDRESS_WIDTH-1:0] push_rd_i,
  input  logic [WB_DATA_WIDTH-1:0]    push_data_i,
  input  logic                        pop_i,
  input  logic                        kill_en_i,
  input  logic [WB_ADDRESS_WIDTH-1:0] kill_rd_i,
  output wb_entry_t                   head_o,
  output logic [CW-1:0]               count_o,
  output logic [CW-1:0]               count_next_o,
  output logic [NREG-1:0]             pending_mask_o
);

  wb_entry_t        ent_q [DEPTH];
  wb_entry_t        ent_d [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic [DEPTH-1:0] keep;
  logic [CW-1:0]    wr_cnt;

  // NOTE: combinational blocks use blocking '=' so later statements see the
  // values just computed; every output gets a default first so no latch forms.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      keep[i]  = ent_q[i].valid
               && !(pop_i && (i == 0))
               && !(kill_en_i && (ent_q[i].rd == kill_rd_i));
      ent_d[i] = '0;
    end

    // Survivors slide toward the head in their original order.
    wr_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (keep[i]) begin
        ent_d[wr_cnt[IW-1:0]] = ent_q[i];
        wr_cnt                = wr_cnt + CW'(1);
      end
    end

    if (push_i && (wr_cnt != CW'(DEPTH))) begin
      ent_d[wr_cnt[IW-1:0]] = '{valid: 1'b1, rd: push_rd_i, data: push_data_i};
      wr_cnt                = wr_cnt + CW'(1);
    end

    count_d = wr_cnt;
  end

  always_comb begin
    pending_mask_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_q[i].valid) pending_mask_o[ent_q[i].rd] = 1'b1;
    end
    pending_mask_o[0] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking '<=' only. The storage is a
  // handful of flops, so it is cleared outright; a RAM-backed queue would
  // reset only the valid bits and leave the payload uninitialised.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      count_q <= count_d;
    end
  end

  assign head_o       = ent_q[0];
  assign count_o      = count_q;
  assign count_next_o = count_d;

endmodule

// File: rtl/reg_writeback_ctrl.sv
// Register-file writeback arbiter: pipeline results take the write port, LSU
// loads wait in a queue, and a starvation counter forces the queue through.
module reg_writeback_ctrl
  import wb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = WB_DATA_WIDTH,
  parameter int unsigned ADDRESS_WIDTH = WB_ADDRESS_WIDTH,
  parameter int unsigned QUEUE_DEPTH   = WB_QUEUE_DEPTH,
  parameter int unsigned STARVE_LIMIT  = WB_STARVE_LIMIT
) (
  input logic                 clk,
  input logic                 rst_n,
  reg_writeback_ctrl_if.slave wb
);

  localparam int unsigned CW   = $clog2(QUEUE_DEPTH) + 1;
  localparam int unsigned SW   = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned NREG = 2**ADDRESS_WIDTH;

  wb_entry_t                head;
  logic [CW-1:0]            q_count, q_count_next;
  logic [NREG-1:0]          q_pending;
  logic                     head_valid;
  logic                     pipe_stall;
  logic                     lsu_ready;
  logic                     push;
  logic                     kill_en;
  wb_src_e                  src;

  logic [SW-1:0]            starve_q, starve_d;
  logic                     we3_q, we3_d;
  logic [ADDRESS_WIDTH-1:0] a3_q, a3_d;
  logic [DATA_WIDTH-1:0]    wd3_q, wd3_d;

  assign head_valid = head.valid;
  assign pipe_stall = head_valid && (starve_q == SW'(STARVE_LIMIT));
  // Full blocks the LSU even while the head drains: no same-cycle bypass.
  assign lsu_ready  = (q_count != CW'(QUEUE_DEPTH));

  always_comb begin
    src = SRC_NONE;
    if (wb.pipe_valid && !pipe_stall) src = SRC_PIPE;
    else if (head_valid)              src = SRC_QUEUE;
  end

  // x0 loads still complete their handshake but never occupy a slot.
  assign push    = wb.lsu_valid && lsu_ready && (wb.lsu_rd != '0);
  // A pipe write supersedes older queued writes to the same register.
  assign kill_en = (src == SRC_PIPE) && (wb.pipe_rd != '0);

  wb_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk            (clk),
    .rst_n          (rst_n),
    .push_i         (push),
    .push_rd_i      (wb.lsu_rd),
    .push_data_i    (wb.lsu_data),
    .pop_i          (src == SRC_QUEUE),
    .kill_en_i      (kill_en),
    .kill_rd_i      (wb.pipe_rd),
    .head_o         (head),
    .count_o        (q_count),
    .count_next_o   (q_count_next),
    .pending_mask_o (q_pending)
  );

  always_comb begin
    we3_d = 1'b0;
    a3_d  = a3_q;
    wd3_d = wd3_q;
    unique case (src)
      SRC_PIPE: begin
        we3_d = (wb.pipe_rd != '0);
        a3_d  = wb.pipe_rd;
        wd3_d = wb.pipe_data;
      end
      SRC_QUEUE: begin
        we3_d = 1'b1;
        a3_d  = head.rd;
        wd3_d = head.data;
      end
      default: ;
    endcase
  end

  // Counts consecutive cycles the head loses to the pipe; an empty queue after
  // this edge (including one emptied by a kill) restarts the count.
  always_comb begin
    if ((src == SRC_QUEUE) || (q_count_next == '0)) starve_d = '0;
    else if ((src == SRC_PIPE) && head_valid)       starve_d = starve_q + SW'(1);
    else                                            starve_d = starve_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we3_q    <= 1'b0;
      a3_q     <= '0;
      wd3_q    <= '0;
      starve_q <= '0;
    end else begin
      we3_q    <= we3_d;
      a3_q     <= a3_d;
      wd3_q    <= wd3_d;
      starve_q <= starve_d;
    end
  end

  assign wb.pipe_stall   = pipe_stall;
  assign wb.lsu_ready    = lsu_ready;
  assign wb.WE3          = we3_q;
  assign wb.A3           = a3_q;
  assign wb.WD3          = wd3_q;
  assign wb.pending_mask = q_pending;
  assign wb.queue_count  = q_count;

endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// Randomised and directed checks of reg_writeback_ctrl against a queue-based
// reference model of the writeback arbitration rules.
module tb_reg_writeback_ctrl;

  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned QD   = 4;
  localparam int unsigned SL   = 4;
  localparam int unsigned NREG = 32;
  localparam int unsigned CW   = 3;

  typedef struct {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } m_ent_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  reg_writeback_ctrl_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .QUEUE_DEPTH(QD)) bus ();

  reg_writeback_ctrl #(
    .DATA_WIDTH    (DW),
    .ADDRESS_WIDTH (AW),
    .QUEUE_DEPTH   (QD),
    .STARVE_LIMIT  (SL)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wb    (bus)
  );

  m_ent_t        mq[$];
  int            m_starve;
  int            n_checks;
  int            n_fail;
  logic          last_stall;
  logic          last_ready;
  logic          stale_armed;
  logic          stale_seen;
  logic [DW-1:0] stale_data;

  // One clock of stimulus: check combinational status against the model,
  // advance the model, then check the registered write port after the edge.
  task automatic step(input logic pv, input logic [AW-1:0] prd, input logic [DW-1:0] pd,
                      input logic lv, input logic [AW-1:0] lrd, input logic [DW-1:0] ld);
    logic            exp_stall, exp_ready, exp_we, blocked, q_issued;
    logic [AW-1:0]   exp_a;
    logic [DW-1:0]   exp_d;
    logic [NREG-1:0] exp_mask;
    m_ent_t          ent;
    bus.pipe_valid = pv;
    bus.pipe_rd    = prd;
    bus.pipe_data  = pd;
    bus.lsu_valid  = lv;
    bus.lsu_rd     = lrd;
    bus.lsu_data   = ld;
    #1;
    exp_stall = (m_starve == SL) && (mq.size() != 0);
    exp_ready = (mq.size() < QD);
    exp_mask  = '0;
    foreach (mq[i]) exp_mask[mq[i].rd] = 1'b1;

    n_checks++;
    if (bus.pipe_stall !== exp_stall) begin
      n_fail++;
      $display("FAIL pipe_stall @%0t: got %b, expected %b", $time, bus.pipe_stall, exp_stall);
    end
    n_checks++;
    if (bus.lsu_ready !== exp_ready) begin
      n_fail++;
      $display("FAIL lsu_ready @%0t: got %b, expected %b", $time, bus.lsu_ready, exp_ready);
    end
    n_checks++;
    if (bus.queue_count !== CW'(mq.size())) begin
      n_fail++;
      $display("FAIL queue_count @%0t: got %0d, expected %0d", $time, bus.queue_count, mq.size());
    end
    n_checks++;
    if (bus.pending_mask !== exp_mask) begin
      n_fail++;
      $display("FAIL pending_mask @%0t: got %h, expected %h", $time, bus.pending_mask, exp_mask);
    end
    last_stall = bus.pipe_stall;
    last_ready = bus.lsu_ready;

    exp_we   = 1'b0;
    exp_a    = '0;
    exp_d    = '0;
    blocked  = 1'b0;
    q_issued = 1'b0;
    if (pv && !exp_stall) begin
      exp_we  = (prd != 0);
      exp_a   = prd;
      exp_d   = pd;
      blocked = (mq.size() != 0);
      if (prd != 0)
        for (int i = mq.size() - 1; i >= 0; i--)
          if (mq[i].rd == prd) mq.delete(i);
    end else if (mq.size() != 0) begin
      exp_we   = 1'b1;
      exp_a    = mq[0].rd;
      exp_d    = mq[0].data;
      q_issued = 1'b1;
      void'(mq.pop_front());
    end
    if (lv && exp_ready && (lrd != 0)) begin
      ent.rd   = lrd;
      ent.data = ld;
      mq.push_back(ent);
    end
    if (q_issued || (mq.size() == 0)) m_starve = 0;
    else if (blocked)                 m_starve++;

    @(posedge clk);
    #1;
    n_checks++;
    if (bus.WE3 !== exp_we) begin
      n_fail++;
      $display("FAIL WE3 @%0t: got %b, expected %b", $time, bus.WE3, exp_we);
    end
    if (exp_we) begin
      n_checks++;
      if ((bus.A3 !== exp_a) || (bus.WD3 !== exp_d)) begin
        n_fail++;
        $display("FAIL write A3/WD3 @%0t: got %0d/%h, expected %0d/%h",
                 $time, bus.A3, bus.WD3, exp_a, exp_d);
      end
    end
    if (stale_armed && (bus.WE3 === 1'b1) && (bus.WD3 === stale_data)) stale_seen = 1'b1;
  endtask

  task automatic idle();
    step(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic drain();
    int guard = 0;
    while ((mq.size() != 0) && (guard < 3 * QD)) begin
      idle();
      guard++;
    end
    n_checks++;
    if (bus.queue_count !== '0) begin
      n_fail++;
      $display("FAIL drain: queue_count got %0d, expected 0", bus.queue_count);
    end
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    bus.pipe_valid = 1'b0;
    bus.pipe_rd    = '0;
    bus.pipe_data  = '0;
    bus.lsu_valid  = 1'b0;
    bus.lsu_rd     = '0;
    bus.lsu_data   = '0;
    mq.delete();
    m_starve = 0;
    #12;
    n_checks++;
    if ({bus.WE3, bus.pipe_stall, bus.lsu_ready} !== 3'b001) begin
      n_fail++;
      $display("FAIL reset WE3/pipe_stall/lsu_ready: got %b%b%b, expected 001",
               bus.WE3, bus.pipe_stall, bus.lsu_ready);
    end
    n_checks++;
    if ((bus.queue_count !== '0) || (bus.pending_mask !== '0)) begin
      n_fail++;
      $display("FAIL reset queue_count/pending_mask: got %0d/%h, expected 0/0",
               bus.queue_count, bus.pending_mask);
    end
    n_checks++;
    if ((bus.A3 !== '0) || (bus.WD3 !== '0)) begin
      n_fail++;
      $display("FAIL reset A3/WD3: got %0d/%h, expected 0/0", bus.A3, bus.WD3);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.WE3 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset release WE3: got %b, expected 0", bus.WE3);
    end
  endtask

  task automatic test_pipe_only();
    step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0);
    n_checks++;
    if ({bus.WE3, bus.A3, bus.WD3} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
      n_fail++;
      $display("FAIL pipe_only: got WE3=%b A3=%0d WD3=%h, expected 1/5/deadbeef",
               bus.WE3, bus.A3, bus.WD3);
    end
    idle();
  endtask

  task automatic test_x0_filter();
    step(1'b1, 5'd0, 32'h1234_5678, 1'b1, 5'd0, 32'h9ABC_DEF0);
    n_checks++;
    if ((last_ready !== 1'b1) || (bus.WE3 !== 1'b0) || (bus.queue_count !== '0)) begin
      n_fail++;
      $display("FAIL x0_filter: got ready=%b WE3=%b count=%0d, expected 1/0/0",
               last_ready, bus.WE3, bus.queue_count);
    end
    step(1'b0, '0, '0, 1'b1, 5'd0, 32'h5555_0000);
    n_checks++;
    if ((bus.WE3 !== 1'b0) || (bus.queue_count !== '0)) begin
      n_fail++;
      $display("FAIL x0_lsu_only: got WE3=%b count=%0d, expected 0/0", bus.WE3, bus.queue_count);
    end
  endtask

  task automatic test_backpressure();
    int sent   = 0;
    int cycles = 0;
    int held   = 0;
    while ((sent < 5) && (cycles < 40)) begin
      step(1'b1, AW'(20 + (cycles % 8)), $urandom, 1'b1, AW'(10 + sent), DW'(32'hB000 + sent));
      cycles++;
      if (last_ready) begin
        sent++;
        if (sent == 4) begin
          n_checks++;
          if ((bus.lsu_ready !== 1'b0) || (bus.queue_count !== CW'(4))) begin
            n_fail++;
            $display("FAIL backpressure full: got ready=%b count=%0d, expected 0/4",
                     bus.lsu_ready, bus.queue_count);
          end
        end
      end else begin
        held++;
      end
    end
    n_checks++;
    if ((sent != 5) || (held == 0)) begin
      n_fail++;
      $display("FAIL backpressure: sent %0d held %0d cycles, expected 5 sent after a hold", sent, held);
    end
    drain();
  endtask

  task automatic test_starvation();
    step(1'b1, 5'd9, 32'hAAAA_0000, 1'b1, 5'd7, 32'h0000_0077);
    for (int k = 1; k <= 5; k++) begin
      step(1'b1, 5'd9, DW'(32'hAAAA_0000 + k), 1'b0, '0, '0);
      n_checks++;
      if (last_stall !== ((k == 5) ? 1'b1 : 1'b0)) begin
        n_fail++;
        $display("FAIL starve blocked cycle %0d: pipe_stall got %b, expected %b",
                 k, last_stall, (k == 5));
      end
    end
    n_checks++;
    if ({bus.WE3, bus.A3, bus.WD3} !== {1'b1, 5'd7, 32'h0000_0077}) begin
      n_fail++;
      $display("FAIL starve drain: got WE3=%b A3=%0d WD3=%h, expected 1/7/00000077",
               bus.WE3, bus.A3, bus.WD3);
    end
    drain();
  endtask

  task automatic test_newest_wins();
    stale_data  = 32'h0000_0011;
    stale_seen  = 1'b0;
    stale_armed = 1'b1;
    step(1'b1, 5'd9, 32'h0000_0099, 1'b1, 5'd3, 32'h0000_0011);
    n_checks++;
    if (bus.pending_mask[3] !== 1'b1) begin
      n_fail++;
      $display("FAIL newest_wins queued: pending_mask[3] got %b, expected 1", bus.pending_mask[3]);
    end
    step(1'b1, 5'd3, 32'h0000_0022, 1'b0, '0, '0);
    n_checks++;
    if ((bus.pending_mask[3] !== 1'b0) || (bus.queue_count !== '0) ||
        ({bus.WE3, bus.A3, bus.WD3} !== {1'b1, 5'd3, 32'h0000_0022})) begin
      n_fail++;
      $display("FAIL newest_wins kill: got mask3=%b count=%0d WE3=%b A3=%0d WD3=%h, expected 0/0/1/3/22",
               bus.pending_mask[3], bus.queue_count, bus.WE3, bus.A3, bus.WD3);
    end
    step(1'b1, 5'd3, 32'h0000_0044, 1'b1, 5'd3, 32'h0000_0033);
    n_checks++;
    if ((bus.pending_mask[3] !== 1'b1) || (bus.queue_count !== CW'(1))) begin
      n_fail++;
      $display("FAIL same_cycle_younger_lsu: got mask3=%b count=%0d, expected 1/1",
               bus.pending_mask[3], bus.queue_count);
    end
    idle();
    n_checks++;
    if ({bus.WE3, bus.A3, bus.WD3} !== {1'b1, 5'd3, 32'h0000_0033}) begin
      n_fail++;
      $display("FAIL younger_lsu_issue: got WE3=%b A3=%0d WD3=%h, expected 1/3/33",
               bus.WE3, bus.A3, bus.WD3);
    end
    drain();
    stale_armed = 1'b0;
    n_checks++;
    if (stale_seen !== 1'b0) begin
      n_fail++;
      $display("FAIL newest_wins stale: superseded data written, got %b, expected 0", stale_seen);
    end
  endtask

  task automatic test_reset_mid_queue();
    for (int i = 0; i < 3; i++)
      step(1'b1, 5'd20, $urandom, 1'b1, AW'(4 + i), DW'(32'hC000 + i));
    n_checks++;
    if (bus.queue_count !== CW'(3)) begin
      n_fail++;
      $display("FAIL reset_mid_queue setup: queue_count got %0d, expected 3", bus.queue_count);
    end
    bus.pipe_valid = 1'b1;
    bus.pipe_rd    = 5'd5;
    rst_n          = 1'b0;
    #1;
    mq.delete();
    m_starve = 0;
    n_checks++;
    if ((bus.queue_count !== '0) || (bus.WE3 !== 1'b0) || (bus.pending_mask !== '0)) begin
      n_fail++;
      $display("FAIL reset_mid_queue async: got count=%0d WE3=%b mask=%h, expected 0/0/0",
               bus.queue_count, bus.WE3, bus.pending_mask);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.WE3 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_queue held: WE3 got %b, expected 0", bus.WE3);
    end
    bus.pipe_valid = 1'b0;
    bus.lsu_valid  = 1'b0;
    rst_n          = 1'b1;
    #1;
    n_checks++;
    if (bus.WE3 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_queue release: WE3 got %b, expected 0", bus.WE3);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) idle();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      step(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom,
           1'($urandom_range(0, 3) != 0), AW'($urandom_range(0, 7)), $urandom);
    end
    drain();
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    stale_armed = 1'b0;
    stale_seen  = 1'b0;
    stale_data  = '0;
    test_reset();
    test_pipe_only();
    test_x0_filter();
    test_backpressure();
    test_starvation();
    test_newest_wins();
    test_reset_mid_queue();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/reg_writeback_ctrl.md
REG_WRITEBACK_CTRL -- requirements
Module: reg_writeback_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, 32, register data width.
REQ-002 Parameter ADDRESS_WIDTH, 5, register index width.
REQ-003 Parameter QUEUE_DEPTH, 4, LSU write queue entries (power of two, >=2).
REQ-004 Parameter STARVE_LIMIT, 4, consecutive cycles a non-empty queue may be blocked before a forced drain.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 pipe_valid  input  1  pipeline writeback request this cycle.
REQ-008 pipe_rd  input  ADDRESS_WIDTH  pipeline destination register.
REQ-009 pipe_data  input  DATA_WIDTH  pipeline result.
REQ-010 pipe_stall  output  1  pipeline writeback slot withheld; upstream holds its request.
REQ-011 lsu_valid  input  1  LSU writeback request.
REQ-012 lsu_ready  output  1  queue can accept an LSU request.
REQ-013 lsu_rd  input  ADDRESS_WIDTH  LSU destination register.
REQ-014 lsu_data  input  DATA_WIDTH  LSU load data.
REQ-015 WE3  output  1  register file write enable, registered.
REQ-016 A3  output  ADDRESS_WIDTH  register file write address, registered.
REQ-017 WD3  output  DATA_WIDTH  register file write data, registered.
REQ-018 pending_mask  output  2**ADDRESS_WIDTH  bit i set while a valid queued write targets register i.
REQ-019 queue_count  output  $clog2(QUEUE_DEPTH)+1  valid queue entries.

Function
REQ-020 At most one register write SHALL be issued per cycle; WE3/A3/WD3 SHALL update one cycle after the selection decision.
REQ-021 Selection: pipe_valid && !pipe_stall issues the pipe write; otherwise the queue head (if valid) issues; otherwise WE3=0 next cycle.
REQ-022 Writes with rd==0 from either source SHALL never assert WE3; pipe rd=0 is dropped; LSU rd=0 completes handshake but is not enqueued.
REQ-023 lsu_ready = !(queue_count==QUEUE_DEPTH), combinational from state only; an LSU transfer occurs when lsu_valid && lsu_ready.
REQ-024 A full queue SHALL deassert lsu_ready even when a dequeue happens that cycle (no same-cycle bypass).
REQ-025 Queue order SHALL be FIFO; enqueue and dequeue in the same cycle leaves queue_count unchanged.
REQ-026 Newest-wins: an issued pipe write to rd X SHALL invalidate every queued entry with rd X in the same cycle; invalidated entries are discarded without issuing.
REQ-027 An LSU request accepted in the same cycle as a pipe write to the same rd SHALL be enqueued (LSU is younger).
REQ-028 Starve counter SHALL increment each cycle the queue head is valid but blocked by a pipe write, clear on any queue issue or empty queue.
REQ-029 When starve counter == STARVE_LIMIT, pipe_stall SHALL be 1 for exactly that cycle and the queue head SHALL issue.
REQ-030 pending_mask and queue_count SHALL reflect registered state (post-invalidation of the previous edge); bit 0 is always 0.

Reset
REQ-031 rst_n low SHALL asynchronously clear WE3, A3, WD3, all queue valid bits, pointers, starve counter; pending_mask=0, queue_count=0, lsu_ready=1, pipe_stall=0.
REQ-032 Reset mid-operation SHALL discard queued writes; no write is issued in the cycle rst_n releases.

Structure
REQ-033 Package wb_pkg SHALL hold wb_entry_t (valid, rd, data) and default width/depth constants.
REQ-034 Sub-module wb_queue SHALL implement the queue with per-entry kill-by-rd; selection and starve logic stay in the top.

Verification
REQ-035 Pipe-only: pipe_valid, rd=5, data=0xDEADBEEF -> next cycle WE3=1, A3=5, WD3=0xDEADBEEF.
REQ-036 x0 filter: pipe rd=0 and LSU rd=0 -> WE3 stays 0, queue_count stays 0, LSU handshake completes.
REQ-037 Backpressure: 4 LSU writes with pipe_valid held high -> lsu_ready=0 after 4th, 5th held until drain.
REQ-038 Starvation: queue head rd=7, pipe_valid continuous -> pipe_stall=1 on 5th blocked cycle, WE3=1, A3=7 next cycle.
REQ-039 Newest-wins: queue holds rd=3 data=0x11; pipe writes rd=3 data=0x22 -> pending_mask[3]=0, 0x11 never written.
REQ-040 Reset mid-queue: 3 entries queued, rst_n pulsed low -> queue_count=0, WE3=0, no further writes.
